// File: rtl/toggle_decoder.sv
// Recovers a one-cycle pulse per q_in transition and counts pulses per WIN-cycle window.
// t_out rises on the 3rd clk edge counting the sampling edge; results wait on cnt_valid/cnt_ready, unaccepted ones are overwritten and flag overrun.
module toggle_decoder #(
   parameter int CNT_W = 8,
   parameter int WIN   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             q_in,
   output logic             t_out,
   output logic [CNT_W-1:0] cnt,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             sat,
   output logic             overrun
);

   localparam int               WIN_W    = (WIN > 1) ? $clog2(WIN) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

   state_t           state;
   logic             arm_cnt;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] acc_nxt;
   logic             acc_sat;
   logic             acc_sat_nxt;
   logic             sync1;
   logic             sync2;
   logic             hist;
   logic             edge_det;
   logic             win_end;

   assign edge_det = sync2 ^ hist;
   assign win_end  = (state == COUNT) && en && (win_cnt == WIN_LAST);

   // Outside COUNT the history flop follows sync1 so no stale edge survives arming.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
      end else begin
         sync1 <= q_in;
         sync2 <= sync1;
         hist  <= (state == COUNT) ? sync2 : sync1;
      end
   end

   always_comb begin
      acc_nxt     = acc;
      acc_sat_nxt = acc_sat;
      if (edge_det) begin
         if (acc == CNT_MAX) begin
            acc_sat_nxt = 1'b1;
         end else begin
            acc_nxt = acc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         arm_cnt   <= 1'b0;
         win_cnt   <= '0;
         acc       <= '0;
         acc_sat   <= 1'b0;
         t_out     <= 1'b0;
         cnt       <= '0;
         cnt_valid <= 1'b0;
         sat       <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         t_out <= 1'b0;
         if (!en) begin
            state   <= IDLE;
            arm_cnt <= 1'b0;
            win_cnt <= '0;
            acc     <= '0;
            acc_sat <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state <= ARM;
               end
               ARM: begin
                  if (arm_cnt) begin
                     arm_cnt <= 1'b0;
                     state   <= COUNT;
                  end else begin
                     arm_cnt <= 1'b1;
                  end
               end
               COUNT: begin
                  t_out <= edge_det;
                  if (win_end) begin
                     win_cnt <= '0;
                     acc     <= '0;
                     acc_sat <= 1'b0;
                  end else begin
                     win_cnt <= win_cnt + 1'b1;
                     acc     <= acc_nxt;
                     acc_sat <= acc_sat_nxt;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end

         // A new result always wins; it only counts as lost if the old one was not taken this cycle.
         if (!en) begin
            cnt_valid <= 1'b0;
         end else if (win_end) begin
            cnt       <= acc_nxt;
            sat       <= acc_sat_nxt;
            cnt_valid <= 1'b1;
            if (cnt_valid && !cnt_ready) begin
               overrun <= 1'b1;
            end
         end else if (cnt_valid && cnt_ready) begin
            cnt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder: an 8-bit-count instance and a 3-bit-count instance sharing clock and reset.
module tb_toggle_decoder;

   logic       clk;
   logic       reset;
   logic       en;
   logic       q_in;
   logic       cnt_ready;
   logic       t_out;
   logic [7:0] cnt;
   logic       cnt_valid;
   logic       sat;
   logic       overrun;

   logic       en3;
   logic       q3;
   logic       rdy3;
   logic       t_out3;
   logic [2:0] cnt3;
   logic       valid3;
   logic       sat3;
   logic       overrun3;

   int tests  = 0;
   int failed = 0;

   toggle_decoder #(.CNT_W(8), .WIN(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .q_in      (q_in),
      .t_out     (t_out),
      .cnt       (cnt),
      .cnt_valid (cnt_valid),
      .cnt_ready (cnt_ready),
      .sat       (sat),
      .overrun   (overrun)
   );

   toggle_decoder #(.CNT_W(3), .WIN(16)) dut3 (
      .clk       (clk),
      .reset     (reset),
      .en        (en3),
      .q_in      (q3),
      .t_out     (t_out3),
      .cnt       (cnt3),
      .cnt_valid (valid3),
      .cnt_ready (rdy3),
      .sat       (sat3),
      .overrun   (overrun3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge and are sampled at the next one.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en        = 1'b0;
      en3       = 1'b0;
      cnt_ready = 1'b0;
      rdy3      = 1'b0;
      q_in      = 1'b0;
      q3        = 1'b0;
      reset     = 1'b0;
      step();
      step();
      #3 reset = 1'b1;
      step();
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; en3 = 1'b0; q_in = 1'b0; q3 = 1'b0;
      cnt_ready = 1'b0; rdy3 = 1'b0;
      #1 reset = 1'b0;
      step();
      step();
      tests++;
      if (t_out !== 1'b0) begin failed++; $display("FAIL reset_t_out got %b exp 0", t_out); end
      tests++;
      if (cnt !== 8'd0) begin failed++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
      tests++;
      if (cnt_valid !== 1'b0) begin failed++; $display("FAIL reset_cnt_valid got %b exp 0", cnt_valid); end
      tests++;
      if (sat !== 1'b0 || overrun !== 1'b0) begin
         failed++; $display("FAIL reset_flags got sat=%b ov=%b exp 0 0", sat, overrun);
      end
      #3 reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         q_in = ~q_in;
         step();
         tests++;
         if (t_out !== 1'b0 || cnt_valid !== 1'b0) begin
            failed++; $display("FAIL post_reset_idle cyc=%0d got t_out=%b valid=%b exp 0 0", i, t_out, cnt_valid);
         end
      end
   endtask

   task automatic test_periodic();
      logic exp_t;
      do_reset();
      cnt_ready = 1'b1;
      en = 1'b1;
      for (int n = 1; n <= 51; n++) begin
         if (n >= 3 && n % 4 == 3) q_in = ~q_in;
         step();
         exp_t = (n >= 5 && n % 4 == 1);
         tests++;
         if (t_out !== exp_t) begin failed++; $display("FAIL periodic_t_out n=%0d got %b exp %b", n, t_out, exp_t); end
         if (n == 19 || n == 35 || n == 51) begin
            tests++;
            if (cnt_valid !== 1'b1 || cnt !== 8'd4 || sat !== 1'b0) begin
               failed++; $display("FAIL periodic_result n=%0d got v=%b cnt=%0d sat=%b exp 1 4 0", n, cnt_valid, cnt, sat);
            end
         end
         if (n == 20) begin
            tests++;
            if (cnt_valid !== 1'b0 || cnt !== 8'd4) begin
               failed++; $display("FAIL periodic_accept got v=%b cnt=%0d exp 0 4", cnt_valid, cnt);
            end
         end
      end
      tests++;
      if (overrun !== 1'b0) begin failed++; $display("FAIL periodic_overrun got %b exp 0", overrun); end
   endtask

   task automatic test_arm();
      logic exp_t;
      do_reset();
      cnt_ready = 1'b1;
      q_in = 1'b1;
      en = 1'b1;
      for (int n = 1; n <= 35; n++) begin
         if (n inside {6, 17, 22}) q_in = ~q_in;
         step();
         exp_t = (n inside {8, 19, 24});
         tests++;
         if (t_out !== exp_t) begin failed++; $display("FAIL arm_t_out n=%0d got %b exp %b", n, t_out, exp_t); end
         if (n == 19) begin
            tests++;
            if (cnt_valid !== 1'b1 || cnt !== 8'd2) begin
               failed++; $display("FAIL arm_win1 got v=%b cnt=%0d exp 1 2", cnt_valid, cnt);
            end
         end
         if (n == 35) begin
            tests++;
            if (cnt_valid !== 1'b1 || cnt !== 8'd1) begin
               failed++; $display("FAIL arm_win2 got v=%b cnt=%0d exp 1 1", cnt_valid, cnt);
            end
         end
      end
   endtask

   task automatic test_constant();
      do_reset();
      cnt_ready = 1'b1;
      q_in = 1'b1;
      step();
      step();
      en = 1'b1;
      for (int n = 1; n <= 35; n++) begin
         step();
         tests++;
         if (t_out !== 1'b0) begin failed++; $display("FAIL const_t_out n=%0d got %b exp 0", n, t_out); end
         if (n == 19 || n == 35) begin
            tests++;
            if (cnt_valid !== 1'b1 || cnt !== 8'd0 || overrun !== 1'b0) begin
               failed++; $display("FAIL const_result n=%0d got v=%b cnt=%0d ov=%b exp 1 0 0", n, cnt_valid, cnt, overrun);
            end
         end
      end
   endtask

   task automatic test_saturate();
      do_reset();
      rdy3 = 1'b1;
      en3 = 1'b1;
      for (int n = 1; n <= 36; n++) begin
         if (n % 2 == 1 && ((n >= 3 && n <= 15) || (n >= 19 && n <= 33))) q3 = ~q3;
         step();
         if (n == 5) begin
            tests++;
            if (t_out3 !== 1'b1) begin failed++; $display("FAIL sat_first_pulse got %b exp 1", t_out3); end
         end
         if (n == 19) begin
            tests++;
            if (valid3 !== 1'b1 || cnt3 !== 3'd7 || sat3 !== 1'b0 || t_out3 !== 1'b0) begin
               failed++; $display("FAIL sat_win1 got v=%b cnt=%0d sat=%b t=%b exp 1 7 0 0", valid3, cnt3, sat3, t_out3);
            end
         end
         if (n == 35) begin
            tests++;
            if (valid3 !== 1'b1 || cnt3 !== 3'd7 || sat3 !== 1'b1) begin
               failed++; $display("FAIL sat_win2 got v=%b cnt=%0d sat=%b exp 1 7 1", valid3, cnt3, sat3);
            end
         end
         if (n == 36) begin
            tests++;
            if (valid3 !== 1'b0 || sat3 !== 1'b1 || overrun3 !== 1'b0) begin
               failed++; $display("FAIL sat_hold got v=%b sat=%b ov=%b exp 0 1 0", valid3, sat3, overrun3);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      en = 1'b1;
      for (int n = 1; n <= 51; n++) begin
         if (n inside {6, 22, 26, 38, 42, 46}) q_in = ~q_in;
         step();
         if (n >= 19) begin
            tests++;
            if (cnt_valid !== 1'b1) begin failed++; $display("FAIL bp_valid n=%0d got %b exp 1", n, cnt_valid); end
         end
         if (n == 19) begin
            tests++;
            if (cnt !== 8'd1 || overrun !== 1'b0) begin
               failed++; $display("FAIL bp_win1 got cnt=%0d ov=%b exp 1 0", cnt, overrun);
            end
         end
         if (n == 34) begin
            tests++;
            if (overrun !== 1'b0) begin failed++; $display("FAIL bp_early_overrun got %b exp 0", overrun); end
         end
         if (n == 35) begin
            tests++;
            if (cnt !== 8'd2 || overrun !== 1'b1) begin
               failed++; $display("FAIL bp_win2 got cnt=%0d ov=%b exp 2 1", cnt, overrun);
            end
         end
         if (n == 51) begin
            tests++;
            if (cnt !== 8'd3 || overrun !== 1'b1) begin
               failed++; $display("FAIL bp_win3 got cnt=%0d ov=%b exp 3 1", cnt, overrun);
            end
         end
      end
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         tests++;
         if (cnt_valid !== 1'b0 || cnt !== 8'd3 || overrun !== 1'b1) begin
            failed++; $display("FAIL bp_disable cyc=%0d got v=%b cnt=%0d ov=%b exp 0 3 1", i, cnt_valid, cnt, overrun);
         end
      end
      do_reset();
      tests++;
      if (overrun !== 1'b0 || cnt !== 8'd0) begin
         failed++; $display("FAIL bp_reset_clear got ov=%b cnt=%0d exp 0 0", overrun, cnt);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      en = 1'b1;
      for (int n = 1; n <= 37; n++) begin
         if (n inside {6, 22, 26}) q_in = ~q_in;
         cnt_ready = (n == 35 || n == 37);
         step();
         if (n == 35) begin
            tests++;
            if (cnt_valid !== 1'b1 || cnt !== 8'd2 || overrun !== 1'b0) begin
               failed++; $display("FAIL b2b_load got v=%b cnt=%0d ov=%b exp 1 2 0", cnt_valid, cnt, overrun);
            end
         end
         if (n == 36) begin
            tests++;
            if (cnt_valid !== 1'b1) begin failed++; $display("FAIL b2b_hold got %b exp 1", cnt_valid); end
         end
         if (n == 37) begin
            tests++;
            if (cnt_valid !== 1'b0 || cnt !== 8'd2) begin
               failed++; $display("FAIL b2b_accept got v=%b cnt=%0d exp 0 2", cnt_valid, cnt);
            end
         end
      end
      cnt_ready = 1'b0;
   endtask

   task automatic test_partial();
      do_reset();
      cnt_ready = 1'b1;
      en = 1'b1;
      for (int n = 1; n <= 13; n++) begin
         if (n inside {6, 10}) q_in = ~q_in;
         step();
         if (n == 12) begin
            tests++;
            if (t_out !== 1'b1) begin failed++; $display("FAIL partial_pulse got %b exp 1", t_out); end
         end
      end
      en = 1'b0;
      step();
      step();
      step();
      en = 1'b1;
      for (int m = 1; m <= 19; m++) begin
         step();
         if (m == 18) begin
            tests++;
            if (cnt_valid !== 1'b0) begin failed++; $display("FAIL partial_early got %b exp 0", cnt_valid); end
         end
         if (m == 19) begin
            tests++;
            if (cnt_valid !== 1'b1 || cnt !== 8'd0) begin
               failed++; $display("FAIL partial_discard got v=%b cnt=%0d exp 1 0", cnt_valid, cnt);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      en = 1'b1;
      for (int n = 1; n <= 25; n++) begin
         if (n inside {6, 23}) q_in = ~q_in;
         step();
         if (n == 19) begin
            tests++;
            if (cnt_valid !== 1'b1 || cnt !== 8'd1) begin
               failed++; $display("FAIL rmid_win1 got v=%b cnt=%0d exp 1 1", cnt_valid, cnt);
            end
         end
         if (n == 25) begin
            tests++;
            if (t_out !== 1'b1) begin failed++; $display("FAIL rmid_pulse got %b exp 1", t_out); end
         end
      end
      #3 reset = 1'b0;
      #1;
      tests++;
      if (t_out !== 1'b0 || cnt !== 8'd0 || cnt_valid !== 1'b0 || sat !== 1'b0 || overrun !== 1'b0) begin
         failed++; $display("FAIL rmid_async got t=%b cnt=%0d v=%b sat=%b ov=%b exp all 0", t_out, cnt, cnt_valid, sat, overrun);
      end
      en = 1'b0;
      step();
      step();
      #3 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         tests++;
         if (cnt_valid !== 1'b0 || t_out !== 1'b0) begin
            failed++; $display("FAIL rmid_idle cyc=%0d got v=%b t=%b exp 0 0", i, cnt_valid, t_out);
         end
      end
      en = 1'b1;
      for (int m = 1; m <= 19; m++) begin
         step();
         if (m == 18) begin
            tests++;
            if (cnt_valid !== 1'b0) begin failed++; $display("FAIL rmid_early got %b exp 0", cnt_valid); end
         end
         if (m == 19) begin
            tests++;
            if (cnt_valid !== 1'b1 || cnt !== 8'd0) begin
               failed++; $display("FAIL rmid_full_window got v=%b cnt=%0d exp 1 0", cnt_valid, cnt);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_arm();
      test_constant();
      test_saturate();
      test_backpressure();
      test_back_to_back();
      test_partial();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/toggle_decoder.md
TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 Parameter: CNT_W, default 8, toggle-count width.
REQ-002 Parameter: WIN, default 16, measurement window length in clk cycles (2..2^16).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserted low clears all state immediately.
REQ-005 en  input  1  decode enable, synchronous.
REQ-006 q_in  input  1  toggling level from a T-flip-flop stage; asynchronous to clk.
REQ-007 t_out  output  1  recovered toggle pulse, one clk cycle per q_in transition.
REQ-008 cnt  output  CNT_W  toggles counted in last completed window.
REQ-009 cnt_valid  output  1  cnt holds an unconsumed result.
REQ-010 cnt_ready  input  1  consumer accepts cnt when cnt_valid=1 and cnt_ready=1.
REQ-011 sat  output  1  last delivered window count saturated.
REQ-012 overrun  output  1  sticky; a window result was lost.

Function
REQ-013 q_in SHALL pass through a 2-flop synchronizer, then a history flop; edge = sync2 XOR hist.
REQ-014 t_out SHALL pulse high exactly one cycle, 3 rising clk edges after the q_in change is first sampled.
REQ-015 Both rising and falling q_in transitions SHALL each produce one t_out pulse.
REQ-016 FSM states: IDLE, ARM, COUNT.
REQ-017 IDLE: en=0 -> stay; en=1 -> ARM; window counter and accumulator held at 0; t_out=0.
REQ-018 ARM: lasts exactly 2 cycles loading synchronizer/history with q_in; no t_out, no counting; then -> COUNT.
REQ-019 COUNT: window counter runs 0..WIN-1 and wraps to 0; accumulator adds 1 per detected edge.
REQ-020 Accumulator SHALL saturate at 2^CNT_W-1; further edges set an internal sat bit for that window.
REQ-021 On the cycle window counter = WIN-1, result (accumulator incl. an edge in that same cycle) SHALL load into cnt, sat loads window's sat bit, cnt_valid=1; accumulator restarts at 0 next cycle.
REQ-022 Handshake: cnt_valid=1 and cnt_ready=1 at an edge -> cnt_valid=0 next cycle; cnt and sat hold until next load.
REQ-023 cnt_valid SHALL never drop without a handshake except on reset or en=0.
REQ-024 Window end with cnt_valid=1 and no same-cycle handshake: new result overwrites cnt/sat, cnt_valid stays 1, overrun set.
REQ-025 Window end coinciding with handshake: old result accepted, new result loaded, cnt_valid stays 1, no overrun.
REQ-026 overrun SHALL clear only on reset.
REQ-027 en=0 in ARM or COUNT: -> IDLE next cycle, partial window discarded, cnt_valid cleared, cnt/sat/overrun retained.
REQ-028 t_out SHALL be low in IDLE and ARM regardless of q_in.

Reset
REQ-029 reset low: state IDLE; t_out=0, cnt=0, cnt_valid=0, sat=0, overrun=0; synchronizer, history, counters=0.
REQ-030 Reset asserted mid-window SHALL discard all results; after release block sits in IDLE until en=1 sampled.
REQ-031 Reset release SHALL be synchronous-safe: no t_out pulse in first 3 cycles after release.

Verification
REQ-032 WIN=16, en=1, q_in toggled every 4 clk cycles, cnt_ready=1 -> t_out every 4 cycles, each result cnt=4, sat=0.
REQ-033 q_in held constant through two windows -> no t_out, two results cnt=0, overrun=0.
REQ-034 CNT_W=3, q_in toggled every 2 cycles, WIN=16 -> cnt=7, sat=1.
REQ-035 cnt_ready=0 for 3 windows -> cnt_valid=1 throughout, cnt = 3rd window's count, overrun=1 until reset.
REQ-036 q_in=1 when en rises -> no t_out during ARM or first COUNT cycle; first pulse only after next q_in change.
REQ-037 reset pulsed low mid-window with cnt_valid=1 -> all outputs 0 immediately; no result until en then a full WIN cycles in COUNT.
